// File: rtl/mem_arbiter_rr_if.sv
// Request/response and RAM bus bundle for mem_arbiter_rr.
// The master modport is the arbiter; the slave modport is the requesters plus the RAM.
interface mem_arbiter_rr_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int NUM_PORTS    = 4
);
    logic [NUM_PORTS-1:0]                req_read;
    logic [NUM_PORTS-1:0]                req_write;
    logic [NUM_PORTS*ADDRESS_BITS-1:0]   req_address;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_byte_en;
    logic [NUM_PORTS*DATA_WIDTH-1:0]     req_data;
    logic [NUM_PORTS-1:0]                req_ready;
    logic [NUM_PORTS-1:0]                resp_done;
    logic                                resp_error;
    logic [DATA_WIDTH-1:0]               resp_data;
    logic                                d_mem_read;
    logic                                d_mem_write;
    logic [DATA_WIDTH/8-1:0]             d_mem_byte_en;
    logic [ADDRESS_BITS-1:0]             d_mem_address_in;
    logic [DATA_WIDTH-1:0]               d_mem_data_in;
    logic [DATA_WIDTH-1:0]               d_mem_data_out;
    logic                                d_mem_valid;
    logic                                d_mem_ready;

    modport master (
        input  req_read, req_write, req_address, req_byte_en, req_data,
        input  d_mem_data_out, d_mem_valid, d_mem_ready,
        output req_ready, resp_done, resp_error, resp_data,
        output d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in
    );

    modport slave (
        output req_read, req_write, req_address, req_byte_en, req_data,
        output d_mem_data_out, d_mem_valid, d_mem_ready,
        input  req_ready, resp_done, resp_error, resp_data,
        input  d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Arbitrates NUM_PORTS requesters onto one RAM port, one transfer at a time
// (IDLE -> ACCESS -> RESP), fixed-priority or round-robin, with access timeout.
module mem_arbiter_rr #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 32,
    parameter int NUM_PORTS      = 4,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_arbiter_rr_if.master             bus,
    output logic                         busy,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id
);
    localparam int BW     = DATA_WIDTH / 8;
    localparam int GW     = $clog2(NUM_PORTS);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_INT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [GW-1:0]           ptr_reg, ptr_next;
    logic [GW-1:0]           grant_reg, grant_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [ADDRESS_BITS-1:0] addr_reg, addr_next;
    logic [BW-1:0]           be_reg, be_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic                    is_read_reg, is_read_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    err_reg, err_next;

    logic [ADDRESS_BITS-1:0] port_addr [NUM_PORTS];
    logic [BW-1:0]           port_be   [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   port_data [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
            assign port_addr[gi] = bus.req_address[gi*ADDRESS_BITS +: ADDRESS_BITS];
            assign port_be[gi]   = bus.req_byte_en[gi*BW +: BW];
            assign port_data[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Rotate the request vector so the search always starts at offset 0.
    logic [NUM_PORTS-1:0]   requesting, rotated;
    logic [2*NUM_PORTS-1:0] req_twice;
    logic [GW-1:0]          start_idx, winner;
    logic                   any_req;
    int                     offset;

    always_comb begin
        requesting = bus.req_read | bus.req_write;
        start_idx  = (ARB_MODE == 1) ? ptr_reg : '0;
        req_twice  = {requesting, requesting};
        rotated    = req_twice[start_idx +: NUM_PORTS];
        any_req    = |requesting;
        offset     = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (rotated[k]) offset = k;
        end
        winner = GW'((int'(start_idx) + offset) % NUM_PORTS);
    end

    logic [NUM_PORTS-1:0]    ready_c, done_c;
    logic                    err_c, mem_rd_c, mem_wr_c, complete;
    logic [DATA_WIDTH-1:0]   rdata_c, mem_wdata_c;
    logic [BW-1:0]           mem_be_c;
    logic [ADDRESS_BITS-1:0] mem_addr_c;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        be_next      = be_reg;
        data_next    = data_reg;
        is_read_next = is_read_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;
        ready_c      = '0;
        done_c       = '0;
        err_c        = 1'b0;
        rdata_c      = '0;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        mem_be_c     = '0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        complete     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    // Gated so req_ready stays low while reset is held.
                    ready_c[winner] = ~reset;
                    state_next      = ACCESS;
                    grant_next      = winner;
                    ptr_next        = (winner == GW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
                    cnt_next        = '0;
                    addr_next       = port_addr[winner];
                    be_next         = port_be[winner];
                    data_next       = port_data[winner];
                    is_read_next    = bus.req_read[winner];
                end
            end
            ACCESS: begin
                mem_rd_c    = is_read_reg;
                mem_wr_c    = ~is_read_reg;
                mem_be_c    = be_reg;
                mem_addr_c  = addr_reg;
                mem_wdata_c = is_read_reg ? '0 : data_reg;
                complete    = is_read_reg ? bus.d_mem_valid : bus.d_mem_ready;
                if (complete) begin
                    state_next = RESP;
                    err_next   = 1'b0;
                    rdata_next = is_read_reg ? bus.d_mem_data_out : '0;
                end else if (TIMEOUT_CYCLES > 0 && cnt_reg == TO_LAST) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                done_c[grant_reg] = 1'b1;
                err_c             = err_reg;
                rdata_c           = rdata_reg;
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            be_reg      <= '0;
            data_reg    <= '0;
            is_read_reg <= 1'b0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            be_reg      <= be_next;
            data_reg    <= data_next;
            is_read_reg <= is_read_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
        end
    end

    assign bus.req_ready        = ready_c;
    assign bus.resp_done        = done_c;
    assign bus.resp_error       = err_c;
    assign bus.resp_data        = rdata_c;
    assign bus.d_mem_read       = mem_rd_c;
    assign bus.d_mem_write      = mem_wr_c;
    assign bus.d_mem_byte_en    = mem_be_c;
    assign bus.d_mem_address_in = mem_addr_c;
    assign bus.d_mem_data_in    = mem_wdata_c;
    assign busy                 = (state_reg != IDLE);
    assign grant_id             = grant_reg;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench: a round-robin arbiter fed by random request rounds and a
// random-latency RAM, plus a fixed-priority instance driven directly.
module tb_mem_arbiter_rr;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NP = 4;
    localparam int BW = DW / 8;
    localparam int GW = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NUM_PORTS(NP)) bus ();
    mem_arbiter_rr_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NUM_PORTS(NP)) bus_fp ();
    logic          busy, busy_fp;
    logic [GW-1:0] grant_id, grant_id_fp;

    mem_arbiter_rr #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NUM_PORTS(NP),
                     .ARB_MODE(1), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id));

    mem_arbiter_rr #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .NUM_PORTS(NP),
                     .ARB_MODE(0), .TIMEOUT_CYCLES(TO)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp), .busy(busy_fp), .grant_id(grant_id_fp));

    // lat = number of strobe cycles before the RAM answers; 0 = never answers.
    typedef struct {
        int            port;
        bit            rd;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
        bit            chained;
    } txn_t;

    txn_t exp_q[$];
    txn_t ram_q[$];
    txn_t slot[NP];
    int   checks = 0;
    int   errors = 0;
    int   model_ptr = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RAM model: answers after the latency the scoreboard chose, with noise on the unused handshake.
    initial begin
        txn_t rt;
        int   acc;
        bit   hit;
        acc = 0;
        rt.lat = 1;
        rt.rdata = '0;
        bus.d_mem_valid = 1'b0;
        bus.d_mem_ready = 1'b0;
        bus.d_mem_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.d_mem_read || bus.d_mem_write) begin
                if (acc == 0) begin
                    if (ram_q.size() > 0) rt = ram_q.pop_front();
                    else rt.lat = 1;
                end
                acc++;
                hit = (rt.lat != 0) && (acc == rt.lat);
                bus.d_mem_valid    = bus.d_mem_read  ? hit : 1'($urandom_range(0, 1));
                bus.d_mem_ready    = bus.d_mem_write ? hit : 1'($urandom_range(0, 1));
                bus.d_mem_data_out = hit ? rt.rdata : DW'($urandom);
            end else begin
                acc = 0;
                bus.d_mem_valid    = 1'b0;
                bus.d_mem_ready    = 1'b0;
                bus.d_mem_data_out = DW'($urandom);
            end
        end
    end

    // Monitor: compares every grant, RAM access and completion against the queue head.
    initial begin
        txn_t          cur;
        int            cyc, strobes, prev_strobes, last_grant, exp_strobes;
        bit            active;
        logic [DW-1:0] exp_data;
        cyc = 0; strobes = 0; prev_strobes = 0; last_grant = 0; active = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                active = 1'b0;
            end else begin
                if (|bus.req_ready) begin
                    check("grant_onehot", $countones(bus.req_ready), 1);
                    check("grant_busy", busy, 0);
                    if (exp_q.size() == 0) begin
                        check("grant_unexpected", bus.req_ready, 0);
                    end else begin
                        cur = exp_q[0];
                        check("grant_port", bus.req_ready, 64'(1) << cur.port);
                        if (cur.chained) check("grant_spacing", cyc - last_grant, prev_strobes + 2);
                        last_grant = cyc;
                        strobes = 0;
                        active = 1'b1;
                    end
                end
                if (bus.d_mem_read || bus.d_mem_write) begin
                    strobes++;
                    if (active && strobes == 1) begin
                        check("access_op", {bus.d_mem_read, bus.d_mem_write}, cur.rd ? 2'b10 : 2'b01);
                        check("access_addr", bus.d_mem_address_in, cur.addr);
                        check("access_be", bus.d_mem_byte_en, cur.be);
                        check("access_wdata", bus.d_mem_data_in, cur.rd ? '0 : cur.wdata);
                    end
                end
                if (|bus.resp_done) begin
                    if (!active) begin
                        check("done_unexpected", bus.resp_done, 0);
                    end else begin
                        exp_strobes = (cur.lat == 0) ? TO : cur.lat;
                        exp_data    = (cur.lat == 0 || !cur.rd) ? '0 : cur.rdata;
                        check("done_port", bus.resp_done, 64'(1) << cur.port);
                        check("done_error", bus.resp_error, (cur.lat == 0) ? 1 : 0);
                        check("done_data", bus.resp_data, exp_data);
                        check("done_strobes", strobes, exp_strobes);
                        check("done_grant_id", grant_id, cur.port);
                        $display("txn port=%0d %s addr=0x%08h lat=%0d err=%0b data=0x%08h",
                                 cur.port, cur.rd ? "RD" : "WR", cur.addr, cur.lat,
                                 bus.resp_error, bus.resp_data);
                        prev_strobes = strobes;
                        void'(exp_q.pop_front());
                        active = 1'b0;
                    end
                end
            end
        end
    end

    // op: 0 read, 1 write, 2 read+write (must behave as a read).
    task automatic setup_port(input int p, input int op, input logic [AW-1:0] a,
                              input logic [BW-1:0] be, input logic [DW-1:0] wd,
                              input int lat, input logic [DW-1:0] rdv);
        slot[p].port  = p;
        slot[p].rd    = (op != 1);
        slot[p].addr  = a;
        slot[p].be    = be;
        slot[p].wdata = wd;
        slot[p].lat   = lat;
        slot[p].rdata = rdv;
        bus.req_read[p]  = (op != 1);
        bus.req_write[p] = (op != 0);
        bus.req_address[p*AW +: AW] = a;
        bus.req_byte_en[p*BW +: BW] = be;
        bus.req_data[p*DW +: DW]    = wd;
    endtask

    task automatic setup_random(input int p, input int lat);
        setup_port(p, $urandom_range(0, 2), AW'($urandom), BW'($urandom), DW'($urandom),
                   lat, DW'($urandom));
    endtask

    // Reference order: serve the pending set from the pointer, wrapping, pointer = winner+1.
    task automatic launch(input logic [NP-1:0] mask);
        logic [NP-1:0] pend, g;
        int            w, p, budget;
        bit            first;
        pend = mask;
        first = 1'b1;
        while (pend != 0) begin
            w = -1;
            for (int k = 0; k < NP; k++) begin
                p = (model_ptr + k) % NP;
                if (w < 0 && pend[p]) w = p;
            end
            slot[w].chained = !first;
            first = 1'b0;
            exp_q.push_back(slot[w]);
            ram_q.push_back(slot[w]);
            pend[w] = 1'b0;
            model_ptr = (w + 1) % NP;
        end
        pend = mask;
        budget = 0;
        while (pend != 0 && budget < 200) begin
            @(negedge clk);
            g = bus.req_ready;
            @(posedge clk);
            #1;
            for (int q = 0; q < NP; q++) begin
                if (g[q]) begin
                    bus.req_read[q]  = 1'b0;
                    bus.req_write[q] = 1'b0;
                end
            end
            pend = pend & ~g;
            budget++;
        end
        check("grant_wait", pend, 0);
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_wait", exp_q.size(), 0);
        exp_q.delete();
        ram_q.delete();
    endtask

    initial begin
        logic [NP-1:0] mask, g, got;
        int            budget, ngrant;
        bit            seen;
        bus.req_read = '0;  bus.req_write = '0;
        bus.req_address = '0; bus.req_byte_en = '0; bus.req_data = '0;
        bus_fp.req_read = '0; bus_fp.req_write = '0;
        bus_fp.req_address = '0; bus_fp.req_byte_en = '0; bus_fp.req_data = '0;
        bus_fp.d_mem_valid = 1'b1; bus_fp.d_mem_ready = 1'b1; bus_fp.d_mem_data_out = '0;
        bus.req_read[2] = 1'b1;
        #1;
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_grant_id", grant_id, 0);
        check("reset_strobes", {bus.d_mem_read, bus.d_mem_write}, 0);
        check("reset_addr", bus.d_mem_address_in, 0);
        check("reset_done", {bus.resp_done, bus.resp_error}, 0);
        check("reset_resp_data", bus.resp_data, 0);
        bus.req_read[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // All four ports requesting, single-cycle RAM: grants 0,1,2,3 three cycles apart.
        for (int p = 0; p < NP; p++) setup_random(p, 1);
        launch(4'b1111);
        // Port 2 reads 0x100, RAM answers after 4 strobe cycles.
        setup_port(2, 0, 32'h100, 4'hF, 32'h0, 4, 32'hDEADBEEF);
        launch(4'b0100);
        // Write that the RAM never acknowledges: timeout after 8 cycles.
        setup_port(1, 1, 32'h2000, 4'h3, 32'hCAFE0001, 0, 32'h0);
        launch(4'b0010);
        // Read+write on port 0 must become a read.
        setup_port(0, 2, 32'h44, 4'hC, 32'h12345678, 2, 32'hA5A5A5A5);
        launch(4'b0001);
        // Completion on the last allowed cycle wins over timeout.
        setup_port(3, 0, 32'h80, 4'hF, 32'h0, TO, 32'h0BADF00D);
        launch(4'b1000);

        for (int r = 0; r < 30; r++) begin
            mask = NP'($urandom_range(1, 15));
            for (int p = 0; p < NP; p++) if (mask[p]) setup_random(p, $urandom_range(0, TO));
            launch(mask);
        end

        // Reset in the middle of an access: leaves pointer at 2 unless reset clears it.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        setup_port(1, 0, 32'h40, 4'hF, 32'h0, 0, 32'h0);
        ram_q.push_back(slot[1]);
        g = '0;
        budget = 0;
        while (!g[1] && budget < 20) begin
            @(negedge clk);
            g = bus.req_ready;
            budget++;
        end
        check("rst_pre_grant", g[1], 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_strobes", {bus.d_mem_read, bus.d_mem_write}, 0);
        check("rst_async_addr", bus.d_mem_address_in, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_grant_id", grant_id, 0);
        check("rst_async_req_ready", bus.req_ready, 0);
        check("rst_async_done", bus.resp_done, 0);
        bus.req_read[1] = 1'b0;
        ram_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if ((|bus.resp_done) || busy) seen = 1'b1;
        end
        check("rst_no_done", seen, 0);
        model_ptr = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        setup_random(0, 1);
        setup_random(3, 2);
        launch(4'b1001);

        // Fixed priority: ports 1 and 3 held, RAM always ready; port 1 wins every 3 cycles.
        @(posedge clk);
        #1;
        bus_fp.req_read = 4'b1010;
        ngrant = 0;
        repeat (24) begin
            @(negedge clk);
            if (|bus_fp.req_ready) begin
                ngrant++;
                check("fp_winner", bus_fp.req_ready, 4'b0010);
            end
        end
        check("fp_grant_count", ngrant, 8);
        @(posedge clk);
        #1;
        bus_fp.req_read = 4'b1000;
        got = '0;
        repeat (6) begin
            @(negedge clk);
            if (got == 0 && (|bus_fp.req_ready)) got = bus_fp.req_ready;
        end
        check("fp_after_release", got, 4'b1000);
        bus_fp.req_read = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
